xgmii_tx_arbiter: RTL and testbench

Shares one 64-bit XGMII TX lane between two frame sources: source 0 is the measurement traffic generator and source 1 is the control/ARP frame builder. Grants are given only at frame boundaries, and a minimum inter-frame idle gap is enforced between frames. Source 1 has priority, but a burst limit stops it from starving source 0. A watchdog force-terminates any frame that runs too long. The block sits between the frame generators and the PHY XGMII TX input.

---
 rtl/xgmii_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_xgmii_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_arbiter.sv
// xgmii_tx_arbiter
//   Shares one 64-bit XGMII TX lane between two frame sources. Source 0 is
//   the measurement traffic generator, source 1 the control/ARP builder.
//   Ownership changes only at frame boundaries, every frame is followed by
//   IFG_WORDS idle words, source 1 wins ties until it has taken
//   MAX_CTRL_BURST consecutive grants while source 0 waits, and a watchdog
//   truncates any frame reaching MAX_FRAME_WORDS words.
//
//   Ports
//     sys_clk, sys_rst_n          clock, asynchronous active-low reset
//     srcN_req                    source N has a frame ready
//     srcN_gnt                    source N owns the lane (registered)
//     srcN_txd/txc/last           source N XGMII word and end-of-frame flag
//     xgmii_txd/xgmii_txc         registered XGMII TX word to the PHY
//     frame_abort                 one-cycle pulse on watchdog truncation
//
//   Optional build macro ARB_STATS_EN adds src0_frames, src1_frames and
//   abort_count counters.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | lane free, arbitrate between requests
//   S_ACTIVE0 | forwarding source 0 frame
//   S_ACTIVE1 | forwarding source 1 frame
//   S_GAP     | inserting inter-frame idle words
module xgmii_tx_arbiter #(
  parameter int IFG_WORDS       = 1,
  parameter int MAX_CTRL_BURST  = 4,
  parameter int MAX_FRAME_WORDS = 1200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        src0_req,
  output logic        src0_gnt,
  input  logic [63:0] src0_txd,
  input  logic [7:0]  src0_txc,
  input  logic        src0_last,
  input  logic        src1_req,
  output logic        src1_gnt,
  input  logic [63:0] src1_txd,
  input  logic [7:0]  src1_txc,
  input  logic        src1_last,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
`ifdef ARB_STATS_EN
  output logic [31:0] src0_frames,
  output logic [31:0] src1_frames,
  output logic [15:0] abort_count,
`endif
  output logic        frame_abort
);

  localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_TXD = 64'h07070707070707fd;
  localparam logic [7:0]  CTRL_ALL  = 8'hff;
  localparam logic [7:0]  BURST_MAX = 8'(MAX_CTRL_BURST);
  localparam logic [15:0] WD_LIMIT  = 16'(MAX_FRAME_WORDS - 1);
  localparam logic [3:0]  GAP_INIT  = 4'(IFG_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE0 = 2'd1,
    S_ACTIVE1 = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  burst_cnt_q;
  logic [15:0] word_cnt_q;
  logic [3:0]  gap_cnt_q;
  logic [63:0] txd_q;
  logic [7:0]  txc_q;
  logic        abort_q;
  logic        gnt0_q;
  logic        gnt1_q;

  // Word from whichever source currently owns the lane.
  logic [63:0] act_txd;
  logic [7:0]  act_txc;
  logic        act_last;
  logic        in_active;
  logic        wd_fire;

  always_comb begin
    act_txd  = src0_txd;
    act_txc  = src0_txc;
    act_last = src0_last;
    if (state_q == S_ACTIVE1) begin
      act_txd  = src1_txd;
      act_txc  = src1_txc;
      act_last = src1_last;
    end
  end

  assign in_active = (state_q == S_ACTIVE0) || (state_q == S_ACTIVE1);
  // A word carrying last at the limit still ends the frame normally.
  assign wd_fire   = in_active && !act_last && (word_cnt_q == WD_LIMIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      txd_q       <= IDLE_TXD;
      txc_q       <= CTRL_ALL;
      abort_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q      <= IDLE_TXD;
          txc_q      <= CTRL_ALL;
          word_cnt_q <= '0;
          // Burst limit only bites while source 0 is actually waiting.
          if (src1_req && ((burst_cnt_q < BURST_MAX) || !src0_req)) begin
            state_q <= S_ACTIVE1;
            gnt1_q  <= 1'b1;
            if (burst_cnt_q != 8'hff) burst_cnt_q <= burst_cnt_q + 8'd1;
          end else if (src0_req) begin
            state_q     <= S_ACTIVE0;
            gnt0_q      <= 1'b1;
            burst_cnt_q <= '0;
          end
        end

        S_ACTIVE0, S_ACTIVE1: begin
          word_cnt_q <= word_cnt_q + 16'd1;
          if (wd_fire) begin
            txd_q   <= ABORT_TXD;
            txc_q   <= CTRL_ALL;
            abort_q <= 1'b1;
          end else begin
            txd_q <= act_txd;
            txc_q <= act_txc;
          end
          if (act_last || wd_fire) begin
            state_q   <= S_GAP;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            gap_cnt_q <= GAP_INIT;
          end
        end

        S_GAP: begin
          txd_q <= IDLE_TXD;
          txc_q <= CTRL_ALL;
          if (gap_cnt_q == 4'd0) state_q <= S_IDLE;
          else gap_cnt_q <= gap_cnt_q - 4'd1;
        end

        default: begin
          state_q <= S_IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          txd_q   <= IDLE_TXD;
          txc_q   <= CTRL_ALL;
        end
      endcase
    end
  end

  assign src0_gnt    = gnt0_q;
  assign src1_gnt    = gnt1_q;
  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign frame_abort = abort_q;

`ifdef ARB_STATS_EN
  logic [31:0] src0_frames_q;
  logic [31:0] src1_frames_q;
  logic [15:0] abort_count_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      src0_frames_q <= '0;
      src1_frames_q <= '0;
      abort_count_q <= '0;
    end else begin
      if ((state_q == S_ACTIVE0) && src0_last) src0_frames_q <= src0_frames_q + 32'd1;
      if ((state_q == S_ACTIVE1) && src1_last) src1_frames_q <= src1_frames_q + 32'd1;
      if (wd_fire) abort_count_q <= abort_count_q + 16'd1;
    end
  end

  assign src0_frames = src0_frames_q;
  assign src1_frames = src1_frames_q;
  assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
module tb_xgmii_tx_arbiter;
  localparam int IFG   = 1;
  localparam int BURST = 2;
  localparam int MAXW  = 16;
  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_D = 64'h07070707070707fd;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req  [2];
  logic        last [2];
  logic [63:0] txd  [2];
  logic [7:0]  txc  [2];
  logic        gnt0, gnt1, fabort;
  logic [63:0] xtxd;
  logic [7:0]  xtxc;
`ifdef ARB_STATS_EN
  logic [31:0] s0f, s1f;
  logic [15:0] abc;
`endif

  always #5 clk = ~clk;

  xgmii_tx_arbiter #(
    .IFG_WORDS(IFG), .MAX_CTRL_BURST(BURST), .MAX_FRAME_WORDS(MAXW)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .src0_req(req[0]), .src0_gnt(gnt0), .src0_txd(txd[0]), .src0_txc(txc[0]), .src0_last(last[0]),
    .src1_req(req[1]), .src1_gnt(gnt1), .src1_txd(txd[1]), .src1_txc(txc[1]), .src1_last(last[1]),
    .xgmii_txd(xtxd), .xgmii_txc(xtxc),
`ifdef ARB_STATS_EN
    .src0_frames(s0f), .src1_frames(s1f), .abort_count(abc),
`endif
    .frame_abort(fabort)
  );

  typedef struct { logic [63:0] d; logic [7:0] c; logic ab; } exp_t;
  typedef struct { int src; int words; } frm_t;
  typedef struct { logic r0; logic r1; int len0; int len1;
                   int exp_src; int exp_words; int exp_abort; } vec_t;

  exp_t exp_q[$];
  frm_t frm_log[$];
  int   gap_log[$];
  int   issued[2], done[2], flen[2], idx[2];
  int   gap_run, aborts_seen;
  logic prev_gnt;
  int   nchk, nerr;
  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source models: present frames one word per cycle while granted.
  task automatic agent();
    logic g;
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? gnt0 : gnt1;
      if (g) begin
        if (idx[k] == 0) gap_log.push_back(gap_run);
        txd[k]  = {8'(k + 1), 8'(idx[k]), 16'($urandom), 24'($urandom),
                   (idx[k] == 0) ? 8'hfb : 8'($urandom)};
        txc[k]  = (idx[k] == 0) ? 8'h01 : 8'h00;
        last[k] = (flen[k] > 0) && (idx[k] == flen[k] - 1);
        if (!last[k] && flen[k] == 0 && idx[k] == MAXW - 1) begin
          exp_q.push_back('{d: ABORT_D, c: 8'hff, ab: 1'b1});
          frm_log.push_back('{src: k, words: idx[k] + 1});
          done[k]++;
        end else begin
          exp_q.push_back('{d: txd[k], c: txc[k], ab: 1'b0});
          if (last[k]) begin
            frm_log.push_back('{src: k, words: idx[k] + 1});
            done[k]++;
          end
        end
        idx[k]++;
      end else begin
        idx[k]  = 0;
        req[k]  = (issued[k] > done[k]);
        txd[k]  = {32'($urandom), 32'($urandom)};
        txc[k]  = 8'($urandom);
        last[k] = 1'($urandom);
      end
    end
    if (gnt0 || gnt1) gap_run = 0;
    else gap_run++;
  endtask

  task automatic monitor();
    exp_t e;
    if (fabort === 1'b1) aborts_seen++;
    if (prev_gnt) begin
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL sb_empty: output %0h with no expected word", xtxd);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", xtxd, e.d);
        chk("tx_ctrl", 64'(xtxc), 64'(e.c));
        chk("tx_abort", 64'(fabort), 64'(e.ab));
      end
    end else begin
      chk("idle_data", xtxd, IDLE_D);
      chk("idle_ctrl", 64'(xtxc), 64'hff);
      chk("idle_abort", 64'(fabort), 64'h0);
    end
    chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'h0);
    prev_gnt = gnt0 | gnt1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    agent();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (!(issued[0] == done[0] && issued[1] == done[1] && !gnt0 && !gnt1
             && exp_q.size() == 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      nchk++; nerr++;
      $display("FAIL timeout: issued %0d/%0d done %0d/%0d", issued[0], issued[1], done[0], done[1]);
    end
    repeat (4) step();
  endtask

  task automatic bench_reset_state();
    for (int k = 0; k < 2; k++) begin
      done[k] = issued[k]; idx[k] = 0; req[k] = 1'b0; last[k] = 1'b0;
    end
    exp_q.delete();
    prev_gnt = 1'b0;
  endtask

  initial begin
    int a0, n;
    int order[6];
    nchk = 0; nerr = 0; gap_run = 0; aborts_seen = 0; prev_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      issued[k] = 0; done[k] = 0; flen[k] = 0; idx[k] = 0;
      req[k] = 1'b0; last[k] = 1'b0; txd[k] = '0; txc[k] = '0;
    end
    //          r0    r1    len0 len1 src words abort
    tv[0] = '{1'b1, 1'b0,  9,  0, 0,  9, 0};
    tv[1] = '{1'b0, 1'b1,  0,  3, 1,  3, 0};
    tv[2] = '{1'b1, 1'b1,  5,  4, 1,  4, 0};
    tv[3] = '{1'b1, 1'b0,  1,  0, 0,  1, 0};
    tv[4] = '{1'b0, 1'b1,  0,  2, 1,  2, 0};
    tv[5] = '{1'b1, 1'b0, 16,  0, 0, 16, 0};
    tv[6] = '{1'b0, 1'b1,  0,  0, 1, 16, 1};
    tv[7] = '{1'b1, 1'b0,  0,  0, 0, 16, 1};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt0", 64'(gnt0), 64'h0);
    chk("rst_gnt1", 64'(gnt1), 64'h0);
    chk("rst_txd", xtxd, IDLE_D);
    chk("rst_txc", 64'(xtxc), 64'hff);
    chk("rst_abort", 64'(fabort), 64'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Quiet lane after reset.
    repeat (20) step();

    for (int i = 0; i < 8; i++) begin
      a0 = aborts_seen;
      frm_log.delete();
      if (tv[i].r0) begin flen[0] = tv[i].len0; issued[0]++; end
      if (tv[i].r1) begin flen[1] = tv[i].len1; issued[1]++; end
      wait_quiet();
      if (frm_log.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL vec_frames: vector %0d produced no frame", i);
      end else begin
        chk("vec_first_src", 64'(frm_log[0].src), 64'(tv[i].exp_src));
        chk("vec_words", 64'(frm_log[0].words), 64'(tv[i].exp_words));
      end
      chk("vec_abort", 64'(aborts_seen - a0), 64'(tv[i].exp_abort));
    end

    // Back-to-back src0 frames: gnt low for IFG+1 cycles between them.
    frm_log.delete(); gap_log.delete();
    flen[0] = 9; issued[0] += 2;
    wait_quiet();
    chk("b2b_frames", 64'(frm_log.size()), 64'd2);
    chk("b2b_gap", 64'((gap_log.size() > 1) ? gap_log[1] : -1), 64'(IFG + 1));

    // Burst limit with both requests held.
    frm_log.delete();
    flen[0] = 3; flen[1] = 3; issued[1] += 4; issued[0] += 2;
    wait_quiet();
    order = '{1, 1, 0, 1, 1, 0};
    chk("burst_frames", 64'(frm_log.size()), 64'd6);
    for (int j = 0; j < 6; j++)
      chk("burst_order", 64'((j < frm_log.size()) ? frm_log[j].src : -1), 64'(order[j]));

    // Asynchronous reset in the middle of a frame.
    flen[0] = 0; issued[0]++;
    n = 0;
    while (idx[0] < 5 && n < 50) begin step(); n++; end
    chk("midrst_reached", 64'(idx[0] >= 5), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt0", 64'(gnt0), 64'h0);
    chk("midrst_txd", xtxd, IDLE_D);
    chk("midrst_txc", 64'(xtxc), 64'hff);
    chk("midrst_abort", 64'(fabort), 64'h0);
    bench_reset_state();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Recovery plus traffic for the statistics counters.
    frm_log.delete();
    flen[1] = 4; issued[1]++;
    wait_quiet();
    chk("recover_src", 64'((frm_log.size() > 0) ? frm_log[0].src : -1), 64'd1);
    chk("recover_words", 64'((frm_log.size() > 0) ? frm_log[0].words : -1), 64'd4);
    flen[0] = 2; flen[1] = 3; issued[0] += 5; issued[1] += 2;
    wait_quiet();
    a0 = aborts_seen;
    flen[0] = 0; issued[0]++;
    wait_quiet();
    chk("stats_abort_seen", 64'(aborts_seen - a0), 64'h1);
`ifdef ARB_STATS_EN
    chk("src0_frames", 64'(s0f), 64'd5);
    chk("src1_frames", 64'(s1f), 64'd3);
    chk("abort_count", 64'(abc), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
